keypad_code_unit: RTL and testbench

- Keypad-side datapath that feeds the lock controller FSM.
- Accumulates digit keypresses into an entry buffer and holds the stored user code (UC), the pending new UC and the lock flag.
- Produces the `match` and `ValidUC` qualifiers that the controller samples on command keys.
- Sits between the keypad scanner (`keypress`/`rdy`) and the controller; consumes the controller's registered state outputs.

---
 rtl/lock_pkg.sv | 28 ++
 rtl/code_entry_buffer.sv | 90 +++++++++
 rtl/keypad_code_unit.sv | 106 ++++++++++
 tb/tb_keypad_code_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the keypad lock datapath.
// Holds the key-class constants, the entry-buffer state encoding and the
// key classification helpers used by the entry buffer and the code unit.
package lock_pkg;

  localparam logic [3:0] KEY_CANCEL = 4'd7;
  localparam logic [3:0] KEY_REPRO  = 4'd8;
  localparam logic [3:0] KEY_LOCK   = 4'd9;
  localparam logic [3:0] MAX_DIGIT  = 4'd6;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2,
    OVER    = 2'd3
  } entry_state_e;

  // Digit keys are 0..MAX_DIGIT.
  function automatic logic is_digit(input logic [3:0] key);
    return (key <= MAX_DIGIT);
  endfunction

  // Command keys are cancel, repro and lock (7..9). Keys above 9 are neither.
  function automatic logic is_command(input logic [3:0] key);
    return (key >= KEY_CANCEL) && (key <= KEY_LOCK);
  endfunction

endpackage

// File: rtl/code_entry_buffer.sv
// Digit entry buffer: shift register, digit count and entry state machine.
// Ports:
//   clk, resetN     clock, asynchronous active-low reset
//   keypress, rdy   key value and its one-cycle valid strobe
//   flush           forces the buffer empty and blocks digits (error/success blink)
//   entry_code      buffered digits, most recent in the low nibble
//   digit_count     digits buffered, saturating at CODE_LEN+1
//   full, over      exactly CODE_LEN digits / more than CODE_LEN digits
module code_entry_buffer
  import lock_pkg::*;
#(
  parameter int CODE_LEN = 4
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic [3:0]              keypress,
  input  logic                    rdy,
  input  logic                    flush,
  output logic [4*CODE_LEN-1:0]   entry_code,
  output logic [3:0]              digit_count,
  output logic                    full,
  output logic                    over
);

  localparam int W = 4 * CODE_LEN;

  entry_state_e   state_q, state_d;
  logic [W-1:0]   code_q, code_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           digit_stb;
  logic           cmd_stb;

  assign digit_stb = rdy & is_digit(keypress);
  assign cmd_stb   = rdy & is_command(keypress);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    // Flush wins over a coincident digit; a command clears on the next edge
    // while the top level still sees the pre-clear contents this cycle.
    if (flush | cmd_stb) begin
      state_d = EMPTY;
      code_d  = '0;
      cnt_d   = '0;
    end else if (digit_stb) begin
      code_d = {code_q[W-5:0], keypress};
      case (state_q)
        EMPTY: begin
          cnt_d   = 4'd1;
          state_d = PARTIAL;
        end
        PARTIAL: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == 4'(CODE_LEN)) state_d = FULL;
        end
        FULL: begin
          cnt_d   = 4'(CODE_LEN + 1);
          state_d = OVER;
        end
        OVER: begin
          // Count saturates; the buffer keeps shifting.
          cnt_d = 4'(CODE_LEN + 1);
        end
        default: begin
          state_d = EMPTY;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= EMPTY;
      code_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  assign entry_code  = code_q;
  assign digit_count = cnt_q;
  assign full        = (state_q == FULL);
  assign over        = (state_q == OVER);

endmodule

// File: rtl/keypad_code_unit.sv
// Keypad-side datapath for the lock controller.
// Accumulates digits, holds the user code, the pending new code and the lock
// flag, and produces the match/ValidUC qualifiers the controller samples on
// command keys.
// Ports:
//   clk, resetN          clock, asynchronous active-low reset
//   keypress, rdy        key value and one-cycle valid strobe
//   CheckPC              compare entry against the programming code
//   CheckValidUC         new-code entry phase
//   confirmUC            compare entry against the pending code
//   ToggleLED1           one-cycle pulse that toggles the lock flag
//   error, Chillin       blink states; digits dropped, buffer held empty
//   match, ValidUC       combinational qualifiers from registered state
//   locked               lock flag
//   digit_count          digits buffered (saturates at CODE_LEN+1)
module keypad_code_unit
  import lock_pkg::*;
#(
  parameter int                    CODE_LEN   = 4,
  parameter logic [4*CODE_LEN-1:0] PC_CODE    = 16'h1234,
  parameter logic [4*CODE_LEN-1:0] UC_DEFAULT = 16'h0000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [3:0] keypress,
  input  logic       rdy,
  input  logic       CheckPC,
  input  logic       CheckValidUC,
  input  logic       confirmUC,
  input  logic       ToggleLED1,
  input  logic       error,
  input  logic       Chillin,
  output logic       match,
  output logic       ValidUC,
  output logic       locked,
  output logic [3:0] digit_count
);

  localparam int W = 4 * CODE_LEN;

  logic [W-1:0] entry_code;
  logic [W-1:0] reference;
  logic         full;
  logic         over;
  logic         entry_ok;
  logic         repro_stb;

  logic [W-1:0] pending_q, pending_d;
  logic [W-1:0] user_code_q, user_code_d;
  logic         locked_q, locked_d;

  code_entry_buffer #(
    .CODE_LEN (CODE_LEN)
  ) u_entry (
    .clk         (clk),
    .resetN      (resetN),
    .keypress    (keypress),
    .rdy         (rdy),
    .flush       (error | Chillin),
    .entry_code  (entry_code),
    .digit_count (digit_count),
    .full        (full),
    .over        (over)
  );

  // full and over are mutually exclusive; an overflowed entry never qualifies.
  assign entry_ok  = full & ~over;
  assign repro_stb = rdy & (keypress == KEY_REPRO);

  always_comb begin
    if (CheckPC)        reference = PC_CODE;
    else if (confirmUC) reference = pending_q;
    else                reference = user_code_q;
  end

  assign match   = entry_ok & (entry_code == reference);
  assign ValidUC = entry_ok & (entry_code != PC_CODE);

  always_comb begin
    pending_d   = pending_q;
    user_code_d = user_code_q;
    locked_d    = locked_q;
    if (CheckValidUC & repro_stb & ValidUC) begin
      pending_d = entry_code;
    end else if (confirmUC & repro_stb & match) begin
      user_code_d = pending_q;
      pending_d   = '0;
    end
    if (ToggleLED1) locked_d = ~locked_q;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pending_q   <= '0;
      user_code_q <= UC_DEFAULT;
      locked_q    <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      user_code_q <= user_code_d;
      locked_q    <= locked_d;
    end
  end

  assign locked = locked_q;

endmodule

// File: tb/tb_keypad_code_unit.sv
module tb_keypad_code_unit;
  import lock_pkg::*;

  logic       clk = 1'b0;
  logic       resetN;
  logic [3:0] keypress;
  logic       rdy;
  logic       CheckPC, CheckValidUC, confirmUC, ToggleLED1, error, Chillin;
  logic       match, ValidUC, locked;
  logic [3:0] digit_count;

  int n_vec = 0;
  int n_err = 0;

  keypad_code_unit dut (
    .clk          (clk),
    .resetN       (resetN),
    .keypress     (keypress),
    .rdy          (rdy),
    .CheckPC      (CheckPC),
    .CheckValidUC (CheckValidUC),
    .confirmUC    (confirmUC),
    .ToggleLED1   (ToggleLED1),
    .error        (error),
    .Chillin      (Chillin),
    .match        (match),
    .ValidUC      (ValidUC),
    .locked       (locked),
    .digit_count  (digit_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One key strobe lasting one clock; returns #1 after the capturing edge.
  task automatic key_in(input logic [3:0] k);
    @(negedge clk);
    keypress = k;
    rdy      = 1'b1;
    @(posedge clk);
    #1;
    rdy = 1'b0;
  endtask

  task automatic keys4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    key_in(a); key_in(b); key_in(c); key_in(d);
  endtask

  // Command strobe with the qualifiers checked inside the strobe cycle.
  task automatic cmd(input string tag, input logic [3:0] k,
                     input logic exp_match, input logic exp_valid);
    @(negedge clk);
    keypress = k;
    rdy      = 1'b1;
    #1;
    chk({tag, ".match"}, 32'(match), 32'(exp_match));
    chk({tag, ".valid"}, 32'(ValidUC), 32'(exp_valid));
    @(posedge clk);
    #1;
    rdy = 1'b0;
  endtask

  task automatic pulse_toggle();
    @(negedge clk);
    ToggleLED1 = 1'b1;
    @(posedge clk);
    #1;
    ToggleLED1 = 1'b0;
  endtask

  initial begin
    resetN = 1'b0; keypress = 4'd0; rdy = 1'b0;
    CheckPC = 1'b0; CheckValidUC = 1'b0; confirmUC = 1'b0;
    ToggleLED1 = 1'b0; error = 1'b0; Chillin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.match", 32'(match), 32'd0);
    chk("rst.valid", 32'(ValidUC), 32'd0);
    chk("rst.locked", 32'(locked), 32'd0);
    chk("rst.count", 32'(digit_count), 32'd0);
    resetN = 1'b1;

    // Default code 0000 then lock key.
    keys4(0, 0, 0, 0);
    chk("t1.count", 32'(digit_count), 32'd4);
    cmd("t1.k9", KEY_LOCK, 1'b1, 1'b1);
    chk("t1.cleared", 32'(digit_count), 32'd0);
    pulse_toggle();
    chk("t1.locked", 32'(locked), 32'd1);

    // Partial entry.
    key_in(1); key_in(2); key_in(3);
    chk("t2.count", 32'(digit_count), 32'd3);
    cmd("t2.k9", KEY_LOCK, 1'b0, 1'b0);

    // Overflow entry.
    keys4(0, 0, 0, 0); key_in(5);
    chk("t3.count", 32'(digit_count), 32'd5);
    key_in(5);
    chk("t3.sat", 32'(digit_count), 32'd5);
    cmd("t3.k9", KEY_LOCK, 1'b0, 1'b0);

    // Repro: programming code phase.
    CheckPC = 1'b1;
    keys4(1, 2, 3, 4);
    cmd("pc.k8", KEY_REPRO, 1'b1, 1'b0);
    CheckPC = 1'b0;

    // New code entry.
    CheckValidUC = 1'b1;
    keys4(5, 6, 0, 1);
    cmd("new.k8", KEY_REPRO, 1'b0, 1'b1);
    chk("new.pending", 32'(dut.pending_q), 32'h5601);
    CheckValidUC = 1'b0;

    // Confirm.
    confirmUC = 1'b1;
    keys4(5, 6, 0, 1);
    cmd("conf.k8", KEY_REPRO, 1'b1, 1'b1);
    chk("conf.uc", 32'(dut.user_code_q), 32'h5601);
    chk("conf.pending", 32'(dut.pending_q), 32'h0);
    confirmUC = 1'b0;

    // New code in idle mode; old default no longer matches.
    keys4(5, 6, 0, 1);
    cmd("idle.k9", KEY_LOCK, 1'b1, 1'b1);
    keys4(0, 0, 0, 0);
    cmd("idle.old", KEY_LOCK, 1'b0, 1'b1);

    // Pending update, then illegal new code leaves pending alone.
    CheckValidUC = 1'b1;
    keys4(2, 2, 2, 2);
    cmd("p2.k8", KEY_REPRO, 1'b0, 1'b1);
    chk("p2.pending", 32'(dut.pending_q), 32'h2222);
    keys4(1, 2, 3, 4);
    cmd("pcuc.k8", KEY_REPRO, 1'b0, 1'b0);
    chk("pcuc.pending", 32'(dut.pending_q), 32'h2222);
    CheckValidUC = 1'b0;

    // Mismatched confirm leaves user code alone.
    confirmUC = 1'b1;
    keys4(3, 3, 3, 3);
    cmd("bad.k8", KEY_REPRO, 1'b0, 1'b1);
    chk("bad.uc", 32'(dut.user_code_q), 32'h5601);
    chk("bad.pending", 32'(dut.pending_q), 32'h2222);
    confirmUC = 1'b0;

    // Ignored keys and a command clearing the buffer.
    key_in(3); key_in(3);
    key_in(12);
    chk("ign.k12", 32'(digit_count), 32'd2);
    key_in(10);
    chk("ign.k10", 32'(digit_count), 32'd2);
    key_in(KEY_REPRO);
    chk("k8.clears", 32'(digit_count), 32'd0);
    key_in(4); key_in(4);
    key_in(KEY_CANCEL);
    chk("k7.clears", 32'(digit_count), 32'd0);
    chk("k7.uc", 32'(dut.user_code_q), 32'h5601);

    // Error blocks digits, including one arriving with error rising.
    key_in(1);
    @(negedge clk);
    error = 1'b1; keypress = 4'd2; rdy = 1'b1;
    @(posedge clk); #1; rdy = 1'b0;
    chk("err.rise", 32'(digit_count), 32'd0);
    key_in(4); key_in(5);
    chk("err.drop", 32'(digit_count), 32'd0);
    error = 1'b0;
    Chillin = 1'b1;
    key_in(6);
    chk("chill.drop", 32'(digit_count), 32'd0);
    Chillin = 1'b0;
    key_in(6);
    chk("after.blink", 32'(digit_count), 32'd1);
    key_in(KEY_CANCEL);

    // Asynchronous reset mid-entry after a committed code.
    key_in(5); key_in(6);
    chk("ar.pre", 32'(digit_count), 32'd2);
    @(posedge clk); #3;
    resetN = 1'b0;
    #1;
    chk("ar.count", 32'(digit_count), 32'd0);
    chk("ar.locked", 32'(locked), 32'd0);
    chk("ar.uc", 32'(dut.user_code_q), 32'h0000);
    chk("ar.match", 32'(match), 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    keys4(0, 0, 0, 0);
    cmd("ar.dflt", KEY_LOCK, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
